// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one synchronous memory port between the
// instruction-fetch and data requesters, with data priority and a fetch starvation guard.

module mem_arbiter_chk (
    input  logic clk,
    input  logic rst,
    input  logic if_gnt,
    input  logic dm_gnt,
    input  logic if_rvalid,
    input  logic dm_rvalid,
    input  logic mem_re,
    input  logic mem_we,
    input  logic busy
);

    gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(if_gnt && dm_gnt));
    rvalid_exclusive: assert property (@(posedge clk) disable iff (rst) !(if_rvalid && dm_rvalid));
    strobe_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_re && mem_we));
    strobe_only_busy: assert property (@(posedge clk) disable iff (rst) (mem_re || mem_we) |-> busy);

endmodule

module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] LAT_C    = 3'(MEM_LAT);
    localparam logic [2:0] STARVE_C = 3'(STARVE_MAX);

    function automatic logic [2:0] sat_inc(input logic [2:0] cnt, input logic [2:0] max);
        if (cnt >= max) begin
            sat_inc = max;
        end else begin
            sat_inc = cnt + 3'd1;
        end
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    starve_q, starve_d;
    logic [2:0]    wait_q, wait_d;
    logic          sel_dm_q, sel_dm_d;
    logic          op_we_q, op_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_gnt_q, if_gnt_d;
    logic          dm_gnt_q, dm_gnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          dm_rvalid_q, dm_rvalid_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic          dm_win_s;

    // Data wins a contested slot unless fetch has been passed over STARVE_MAX times.
    assign dm_win_s = dm_req & ~(if_req & (starve_q == STARVE_C));

    // Next-state, latched request and registered-output computation.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        sel_dm_d    = sel_dm_q;
        op_we_d     = op_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dm_win_s) begin
                    state_d    = ST_ISSUE;
                    sel_dm_d   = 1'b1;
                    op_we_d    = dm_we;
                    mem_addr_d = dm_addr;
                    dm_gnt_d   = 1'b1;
                    mem_re_d   = ~dm_we;
                    mem_we_d   = dm_we;
                    if (dm_we) begin
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_wdata_d = mem_wdata_q;
                    end
                    if (if_req) begin
                        starve_d = sat_inc(starve_q, STARVE_C);
                    end else begin
                        starve_d = starve_q;
                    end
                end else if (if_req) begin
                    state_d    = ST_ISSUE;
                    sel_dm_d   = 1'b0;
                    op_we_d    = 1'b0;
                    mem_addr_d = if_addr;
                    if_gnt_d   = 1'b1;
                    mem_re_d   = 1'b1;
                    starve_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (op_we_q) begin
                    state_d = ST_IDLE;
                    wait_d  = 3'd0;
                end else begin
                    state_d = ST_WAIT;
                    wait_d  = LAT_C;
                end
            end
            ST_WAIT: begin
                // A zero count can only come from corruption; treat it as the final cycle.
                if (wait_q <= 3'd1) begin
                    state_d = ST_IDLE;
                    wait_d  = 3'd0;
                    if (sel_dm_q) begin
                        dm_rdata_d  = mem_rdata;
                        dm_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT;
                    wait_d  = wait_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = 3'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= 3'd0;
            wait_q      <= 3'd0;
            sel_dm_q    <= 1'b0;
            op_we_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            sel_dm_q    <= sel_dm_d;
            op_we_q     <= op_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

    mem_arbiter_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .if_gnt    (if_gnt_q),
        .dm_gnt    (dm_gnt_q),
        .if_rvalid (if_rvalid_q),
        .dm_rvalid (dm_rvalid_q),
        .mem_re    (mem_re_q),
        .mem_we    (mem_we_q),
        .busy      (busy_q)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A uses MEM_LAT=1, instance B uses MEM_LAT=3.
// Unwritten memory words read as 0xDEADBEEF ^ (addr ^ 0x0010); idle pipeline slots carry 0xBAD0BAD0.

module tb_mem_arbiter;

    logic        clk;
    logic        rst;

    logic        a_if_req, a_if_gnt, a_if_rvalid;
    logic [15:0] a_if_addr;
    logic [31:0] a_if_rdata;
    logic        a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid;
    logic [15:0] a_dm_addr;
    logic [31:0] a_dm_wdata, a_dm_rdata;
    logic        a_mem_re, a_mem_we, a_busy;
    logic [15:0] a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata, a_rd_s;
    logic [31:0] a_mem_arr [256];
    logic [255:0] a_wr_vld;

    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [15:0] b_if_addr;
    logic [31:0] b_if_rdata;
    logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
    logic [15:0] b_dm_addr;
    logic [31:0] b_dm_wdata, b_dm_rdata;
    logic        b_mem_re, b_mem_we, b_busy;
    logic [15:0] b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata, b_rd_s;
    logic [31:0] b_pipe0, b_pipe1, b_pipe2;

    int n_chk;
    int n_pass;

    mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
        .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(3), .STARVE_MAX(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model A: one-cycle read latency, stores tracked per word.
    assign a_rd_s = a_wr_vld[a_mem_addr[7:0]] ? a_mem_arr[a_mem_addr[7:0]]
                                              : (32'hDEADBEEF ^ {16'h0000, a_mem_addr ^ 16'h0010});
    always @(posedge clk) begin
        if (rst) begin
            a_wr_vld <= '0;
        end else if (a_mem_we) begin
            a_wr_vld[a_mem_addr[7:0]]  <= 1'b1;
            a_mem_arr[a_mem_addr[7:0]] <= a_mem_wdata;
        end
        a_mem_rdata <= a_mem_re ? a_rd_s : 32'hBAD0BAD0;
    end

    // Memory model B: three-cycle read pipeline, read-only.
    assign b_rd_s      = 32'hDEADBEEF ^ {16'h0000, b_mem_addr ^ 16'h0010};
    assign b_mem_rdata = b_pipe2;
    always @(posedge clk) begin
        b_pipe0 <= b_mem_re ? b_rd_s : 32'hBAD0BAD0;
        b_pipe1 <= b_pipe0;
        b_pipe2 <= b_pipe1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  seq [8];
        logic [1:0]  exp_seq [8];
        logic        both_seen;
        logic        rst_pulse_seen;
        int          ng;

        n_chk = 0;
        n_pass = 0;
        exp_seq = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2};

        // ---- reset with both requests pending ----
        rst = 1'b1;
        a_if_req = 1'b1; a_if_addr = 16'h0030;
        a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 16'h0020; a_dm_wdata = 32'h0000_0000;
        b_if_req = 1'b0; b_if_addr = 16'h0000;
        b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = 16'h0000; b_dm_wdata = 32'h0000_0000;
        tick();
        tick();
        check_val("rst_ctrl", {25'd0, a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid,
                               a_mem_re, a_mem_we, a_busy}, 32'h0000_0000);
        check_val("rst_mem_addr", {16'h0000, a_mem_addr}, 32'h0000_0000);
        check_val("rst_rdata", a_if_rdata | a_dm_rdata | a_mem_wdata, 32'h0000_0000);
        check_val("rst_b_outs", b_if_rdata | b_mem_wdata | {31'd0, b_if_rvalid}, 32'h0000_0000);

        rst = 1'b0;
        tick();
        check_val("rst_first_dm_gnt", {31'd0, a_dm_gnt}, 32'd1);
        check_val("rst_first_if_gnt", {31'd0, a_if_gnt}, 32'd0);
        check_val("rst_first_addr", {16'h0000, a_mem_addr}, 32'h0000_0020);
        a_dm_req = 1'b0;
        tick();
        tick();
        check_val("rst_load_rvalid", {31'd0, a_dm_rvalid}, 32'd1);
        check_val("rst_load_rdata", a_dm_rdata, 32'hDEADBEDF);
        tick();
        check_val("held_fetch_gnt", {31'd0, a_if_gnt}, 32'd1);
        check_val("held_fetch_addr", {16'h0000, a_mem_addr}, 32'h0000_0030);
        a_if_req = 1'b0;
        tick();
        tick();
        check_val("held_fetch_rdata", a_if_rdata, 32'hDEADBECF);
        tick();

        // ---- single fetch, MEM_LAT=1 ----
        a_if_req = 1'b1; a_if_addr = 16'h0010;
        tick();
        check_val("f1_cyc1", {28'd0, a_if_gnt, a_mem_re, a_busy, a_if_rvalid}, 32'h0000_000E);
        check_val("f1_addr", {16'h0000, a_mem_addr}, 32'h0000_0010);
        a_if_req = 1'b0;
        tick();
        check_val("f1_cyc2", {28'd0, a_if_gnt, a_mem_re, a_busy, a_if_rvalid}, 32'h0000_0002);
        tick();
        check_val("f1_cyc3", {28'd0, a_if_gnt, a_mem_re, a_busy, a_if_rvalid}, 32'h0000_0001);
        check_val("f1_rdata", a_if_rdata, 32'hDEADBEEF);
        tick();
        check_val("f1_rvalid_end", {31'd0, a_if_rvalid}, 32'd0);
        check_val("f1_rdata_hold", a_if_rdata, 32'hDEADBEEF);

        // ---- store then load to 0x0042 ----
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 16'h0042; a_dm_wdata = 32'h1234_5678;
        tick();
        check_val("st_issue", {28'd0, a_dm_gnt, a_mem_we, a_mem_re, a_busy}, 32'h0000_000D);
        check_val("st_addr", {16'h0000, a_mem_addr}, 32'h0000_0042);
        check_val("st_wdata", a_mem_wdata, 32'h1234_5678);
        a_dm_req = 1'b0;
        tick();
        check_val("st_after", {29'd0, a_mem_we, a_dm_rvalid, a_busy}, 32'h0000_0000);
        check_val("st_rdata_kept", a_dm_rdata, 32'hDEADBEDF);
        a_dm_req = 1'b1; a_dm_we = 1'b0;
        tick();
        check_val("ld_issue", {30'd0, a_dm_gnt, a_mem_re}, 32'h0000_0003);
        a_dm_req = 1'b0;
        tick();
        check_val("ld_wait_rvalid", {31'd0, a_dm_rvalid}, 32'd0);
        tick();
        check_val("ld_rvalid", {31'd0, a_dm_rvalid}, 32'd1);
        check_val("ld_rdata", a_dm_rdata, 32'h1234_5678);

        // ---- contention with starvation guard ----
        a_if_req = 1'b1; a_if_addr = 16'h0050;
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 16'h0060; a_dm_wdata = 32'hA5A5_A5A5;
        for (int i = 0; i < 8; i++) seq[i] = 2'd0;
        ng = 0;
        both_seen = 1'b0;
        for (int c = 0; c < 80 && ng < 8; c++) begin
            tick();
            if (a_if_gnt && a_dm_gnt) both_seen = 1'b1;
            if (a_dm_gnt) begin
                seq[ng] = 2'd1;
                ng = ng + 1;
            end else if (a_if_gnt) begin
                seq[ng] = 2'd2;
                ng = ng + 1;
            end
        end
        a_if_req = 1'b0;
        a_dm_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("grant_%0d", i), {30'd0, seq[i]}, {30'd0, exp_seq[i]});
        end
        check_val("grant_both", {31'd0, both_seen}, 32'd0);
        tick();
        tick();
        tick();

        // ---- MEM_LAT=3 read on instance B ----
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 16'h0077;
        tick();
        check_val("l3_issue", {27'd0, b_mem_re, b_dm_rvalid, b_busy, b_dm_gnt, b_if_gnt}, 32'h0000_0016);
        b_dm_addr = 16'h0078;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_val($sformatf("l3_wait%0d", k),
                      {27'd0, b_mem_re, b_dm_rvalid, b_busy, b_dm_gnt, b_mem_we}, 32'h0000_0004);
        end
        tick();
        check_val("l3_rvalid", {30'd0, b_dm_rvalid, b_busy}, 32'h0000_0002);
        check_val("l3_rdata", b_dm_rdata, 32'hDEADBE88);
        b_dm_req = 1'b0;
        tick();
        check_val("l3_idle", {29'd0, b_mem_re, b_dm_rvalid, b_busy}, 32'h0000_0000);

        // ---- reset during WAIT on instance B ----
        b_dm_req = 1'b1; b_dm_addr = 16'h0005;
        tick();
        b_dm_req = 1'b0;
        tick();
        check_val("mr_busy_wait", {31'd0, b_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("mr_ctrl", {29'd0, b_busy, b_mem_re, b_dm_rvalid}, 32'h0000_0000);
        check_val("mr_rdata", b_dm_rdata, 32'h0000_0000);
        check_val("mr_addr", {16'h0000, b_mem_addr}, 32'h0000_0000);
        rst_pulse_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (b_dm_rvalid || b_dm_gnt) rst_pulse_seen = 1'b1;
        end
        rst = 1'b0;
        tick();
        if (b_dm_rvalid || b_dm_gnt) rst_pulse_seen = 1'b1;
        check_val("mr_no_pulse", {31'd0, rst_pulse_seen}, 32'd0);
        b_dm_req = 1'b1; b_dm_addr = 16'h0005;
        tick();
        check_val("mr_regrant", {31'd0, b_dm_gnt}, 32'd1);
        b_dm_req = 1'b0;
        tick();
        tick();
        tick();
        check_val("mr_no_early_rvalid", {31'd0, b_dm_rvalid}, 32'd0);
        tick();
        check_val("mr_rvalid", {31'd0, b_dm_rvalid}, 32'd1);
        check_val("mr_rdata_new", b_dm_rdata, 32'hDEADBEFA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the SISC processor. It shares one synchronous memory port between the instruction-fetch requester (driven by the fetch state) and the data requester (driven by LOD/STR in the mem state). It sequences each access through issue, wait and completion. Data accesses have priority, and a starvation guard bounds how long fetch can wait.

## Interface
- AW, 16, address width
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal range 1..7)
- STARVE_MAX, 3, consecutive contested data grants before fetch is forced (legal range 1..7)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  AW  fetch address; stable while if_req=1
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetch read data; holds until next fetch completes
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store (STR), 0 = load (LOD)
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  one-cycle pulse: data request accepted
- dm_rvalid  out  1  one-cycle pulse: dm_rdata valid (loads only)
- dm_rdata  out  DW  load data; holds until next load completes
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_re cycle
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: at a clock edge with any request pending, choose the winner, latch its address, data and op, and go to ISSUE. With no request, stay in IDLE.
- Arbitration:
  - Only dm_req: data wins.
  - Only if_req: fetch wins.
  - Both pending: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments when data wins while if_req=1.
  - Clears when fetch wins.
  - Saturates at STARVE_MAX.
- ISSUE (exactly one cycle):
  - Drive mem_addr and mem_wdata from the latched values.
  - Assert mem_re for a read or mem_we for a store.
  - Pulse the winner's gnt.
  - A read goes to WAIT with wait_cnt = MEM_LAT. A store goes to IDLE.
- WAIT:
  - Decrement wait_cnt each cycle.
  - In the cycle wait_cnt == 1, capture mem_rdata into the winner's rdata register and go to IDLE.
  - The winner's rvalid pulses in the following cycle.
- Outside ISSUE: mem_re = mem_we = 0. mem_addr and mem_wdata hold their last value.
- Request changes while busy are ignored. A request dropped before its gnt is never serviced.
- Stores never assert dm_rvalid, and dm_rdata is unchanged by a store.
- Reset state:
  - state = IDLE; starve_cnt = 0; wait_cnt = 0.
  - All strobes, gnts, rvalids and busy = 0.
  - if_rdata, dm_rdata, mem_addr and mem_wdata = 0.
- Reset asserted mid-transaction:
  - Aborts immediately; no gnt or rvalid for the aborted access.
  - The requester must re-request after reset deasserts.

## Timing
- Request sampled at edge E0; ISSUE occupies cycle E0→E1, with gnt and the strobe high in that cycle.
- Read data is valid from the memory in cycle E(MEM_LAT)→E(MEM_LAT+1) and is captured at edge E(MEM_LAT+1).
- rvalid is high and rdata valid in cycle E(MEM_LAT+1)→E(MEM_LAT+2).
- Read: request-sampled to rvalid = MEM_LAT+1 edges. With MEM_LAT=1, rvalid is high in the 3rd cycle after the request is presented.
- Back-to-back: IDLE coincides with the rvalid cycle, so the next request can be sampled at the edge ending the rvalid cycle.
  - Read throughput: one read per MEM_LAT+2 cycles.
  - Store: occupies 2 cycles (IDLE sample + ISSUE).
- gnt and rvalid are registered, one cycle wide, and never high for both requesters in the same cycle.
- busy is registered: high from the ISSUE cycle through the last WAIT cycle.

## Test plan
- Reset:
  - Stimulus: rst=1 with both reqs high; release.
  - Required response: all outputs 0 while rst=1; first grant at the first edge after release goes to data.
- Single fetch, MEM_LAT=1:
  - Stimulus: if_addr=0x0010, memory returns 0xDEADBEEF.
  - Required response: if_gnt and mem_re in cycle 1; if_rvalid in cycle 3 with if_rdata=0xDEADBEEF; busy high cycles 1–2.
- Store then load to the same address:
  - Stimulus: dm_we=1, dm_addr=0x0042, dm_wdata=0x12345678, followed by a load of 0x0042.
  - Required response: one mem_we cycle with those values; no dm_rvalid for the store; load returns 0x12345678 with dm_rvalid.
- Contention and starvation, STARVE_MAX=3:
  - Stimulus: if_req and dm_req held continuously, with dm_req re-asserted after each grant.
  - Required response: grant order data, data, data, fetch, data…; starve_cnt clears after the fetch grant.
- MEM_LAT=3 read:
  - Stimulus: issue a read with MEM_LAT=3.
  - Required response: dm_rvalid 4 edges after the sample edge; data captured only from the MEM_LAT-th cycle after ISSUE; no second mem_re while busy.
- Mid-read reset:
  - Stimulus: assert rst during WAIT.
  - Required response: state IDLE immediately; no rvalid pulse; dm_rdata=0; a re-request after release completes normally.
